// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package arb_pkg;

  // Widest requester vector the shared helpers accept.
  localparam int unsigned ARB_MAX_N = 64;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Index of the set bit in a one-hot vector, built as the OR of the
  // indices of all set bits. For a one-hot input it is exact and maps to
  // a shallow OR tree; an all-zero input yields 0.
  function automatic int unsigned onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) begin
        idx = idx | i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of req searching upward from start, with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; found is low when req is all zero.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  sel
);

  logic [IW-1:0] pos;

  // Walk the N positions starting at 'start'; the first requesting one wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IW'((32'(start) + k) % N);
      if (!found && req[pos]) begin
        sel[pos] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign idx = IW'(onehot_to_idx(ARB_MAX_N'(sel)));

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with registered one-hot grant held up to MAX_HOLD cycles under contention.
// Latency: request sampled at an edge is granted at that same edge; handoffs have no idle gap.
// Backpressure: owner keeps the grant while requesting; competitors wait for release or hold expiry.
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 2,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         request,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int unsigned IW = $clog2(N);
  // Hold counter only needs to reach MAX_HOLD; keep at least one bit so
  // the unlimited configuration still elaborates cleanly.
  localparam int unsigned CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_HOLD);
  localparam logic          HOLD_EN  = (MAX_HOLD != 0);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic          grant_vld_q, grant_vld_d;

  logic [N-1:0]  owner_mask;
  logic          owner_req;
  logic [N-1:0]  others;
  logic [N-1:0]  cand;
  logic [IW-1:0] start;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_sel;

  logic          take_new;
  logic          go_idle;
  logic          bump_cnt;

  // While busy, last_q is the current owner.
  assign owner_mask = N'(1) << last_q;
  assign owner_req  = request[last_q];
  assign others     = request & ~owner_mask;

  // When busy, every way of choosing a new owner (release handoff or hold
  // expiry) excludes the current owner; a released owner's bit is already
  // low, so one masked candidate vector serves both cases.
  assign cand  = (state_q == ARB_BUSY) ? others : request;
  assign start = (last_q == LAST_RST) ? '0 : last_q + IW'(1);

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (cand),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx),
    .sel   (pick_sel)
  );

  // Decide this cycle's action, then derive every next-state register from it.
  always_comb begin
    take_new    = 1'b0;
    go_idle     = 1'b0;
    bump_cnt    = 1'b0;
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    grant_vld_d = grant_vld_q;

    unique case (state_q)
      ARB_IDLE: begin
        take_new = pick_found;
      end
      ARB_BUSY: begin
        if (!owner_req) begin
          // Owner released: hand straight to a waiter, or fall idle.
          take_new = pick_found;
          go_idle  = !pick_found;
        end else if (HOLD_EN && (cnt_q == CNT_MAX) && pick_found) begin
          // Hold window used up with someone waiting: rotate.
          take_new = 1'b1;
        end else begin
          // Keep the grant; count saturates so a lone owner holds forever.
          bump_cnt = HOLD_EN && (cnt_q != CNT_MAX);
        end
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase

    if (take_new) begin
      state_d     = ARB_BUSY;
      last_d      = pick_idx;
      cnt_d       = CW'(1);
      grant_d     = pick_sel;
      grant_id_d  = pick_idx;
      grant_vld_d = 1'b1;
    end else if (go_idle) begin
      state_d     = ARB_IDLE;
      cnt_d       = '0;
      grant_d     = '0;
      grant_id_d  = '0;
      grant_vld_d = 1'b0;
    end else if (bump_cnt) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State and output registers; reset clears the grant immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      last_q      <= LAST_RST;
      cnt_q       <= '0;
      grant_q     <= '0;
      grant_id_q  <= '0;
      grant_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      grant_vld_q <= grant_vld_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_vld_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: three configurations checked every cycle against an ownership model.
// Latency: model advances on each rising edge, outputs compared on the falling edge.
// Backpressure: n/a.
module tb_rr_hold_arbiter;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [1:0] req_a = '0;
  logic [1:0] req_c = '0;
  logic [3:0] req_d = '0;

  logic [1:0] gnt_a;
  logic       vld_a;
  logic [0:0] id_a;
  logic [1:0] gnt_c;
  logic       vld_c;
  logic [0:0] id_c;
  logic [3:0] gnt_d;
  logic       vld_d;
  logic [1:0] id_d;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // A: default config. C: unlimited hold. D: four requesters, hold of 3.
  rr_hold_arbiter #(.N(2), .MAX_HOLD(4)) u_dut_a (
    .clk(clk), .rst(rst), .request(req_a),
    .grant(gnt_a), .grant_valid(vld_a), .grant_id(id_a)
  );
  rr_hold_arbiter #(.N(2), .MAX_HOLD(0)) u_dut_c (
    .clk(clk), .rst(rst), .request(req_c),
    .grant(gnt_c), .grant_valid(vld_c), .grant_id(id_c)
  );
  rr_hold_arbiter #(.N(4), .MAX_HOLD(3)) u_dut_d (
    .clk(clk), .rst(rst), .request(req_d),
    .grant(gnt_d), .grant_valid(vld_d), .grant_id(id_d)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Ownership model: who owns the resource, who owned it last, for how long.
  typedef struct {
    int owner;   // -1 when idle
    int last;
    int held;
  } mdl_t;

  function automatic int pick(input int n, input int last, input logic [3:0] cand);
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (last + k) % n;
      if (cand[i]) return i;
    end
    return -1;
  endfunction

  function automatic mdl_t mdl_reset(input int n);
    mdl_t r;
    r.owner = -1;
    r.last  = n - 1;
    r.held  = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input int n, input int m, input logic [3:0] req);
    mdl_t r;
    logic [3:0] others;
    r = s;
    if (r.owner < 0) begin
      if (req != 0) begin
        r.owner = pick(n, r.last, req);
        r.last  = r.owner;
        r.held  = 1;
      end
    end else begin
      others = req & ~(4'b0001 << r.owner);
      if (!req[r.owner]) begin
        if (others != 0) begin
          r.owner = pick(n, r.last, others);
          r.last  = r.owner;
          r.held  = 1;
        end else begin
          r.owner = -1;
        end
      end else if (m > 0 && r.held >= m && others != 0) begin
        r.owner = pick(n, r.last, others);
        r.last  = r.owner;
        r.held  = 1;
      end else begin
        r.held = r.held + 1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_gnt(input mdl_t s);
    return (s.owner < 0) ? 32'd0 : (32'd1 << s.owner);
  endfunction

  function automatic logic [31:0] exp_id(input mdl_t s);
    return (s.owner < 0) ? 32'd0 : 32'(s.owner);
  endfunction

  mdl_t ma, mc, md;

  // Advance the models on every rising edge; reset them with the DUTs.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= mdl_reset(2);
      mc <= mdl_reset(2);
      md <= mdl_reset(4);
    end else begin
      ma <= mdl_step(ma, 2, 4, {2'b00, req_a});
      mc <= mdl_step(mc, 2, 0, {2'b00, req_c});
      md <= mdl_step(md, 4, 3, req_d);
    end
  end

  // Compare all three DUTs against their models mid-cycle.
  always @(negedge clk) begin
    chk("a_grant", gnt_a, exp_gnt(ma));
    chk("a_valid", vld_a, (ma.owner >= 0) ? 32'd1 : 32'd0);
    chk("a_id",    id_a,  exp_id(ma));
    chk("c_grant", gnt_c, exp_gnt(mc));
    chk("c_valid", vld_c, (mc.owner >= 0) ? 32'd1 : 32'd0);
    chk("c_id",    id_c,  exp_id(mc));
    chk("d_grant", gnt_d, exp_gnt(md));
    chk("d_valid", vld_d, (md.owner >= 0) ? 32'd1 : 32'd0);
    chk("d_id",    id_d,  exp_id(md));
  end

  // Advance to 3 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    cyc();
    rst   = 1'b0;
    req_a = '0;
    req_c = '0;
    req_d = '0;
    cyc();
    rst = 1'b1;
  endtask

  logic [1:0] rot_seq [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

  initial begin
    // Power-on reset, then a single request from requester 0.
    #1  rst = 1'b0;
    #11 rst = 1'b1;
    #2;
    chk("pre_grant", gnt_a, 32'd0);
    req_a = 2'b01;
    @(posedge clk);
    #1;
    chk("first_grant", gnt_a, 32'd1);
    chk("first_model", exp_gnt(ma), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("still_granted", gnt_a, 32'd1);

    // Simultaneous requests out of reset: 4-cycle rotation; C never rotates.
    do_reset();
    req_a = 2'b11;
    req_c = 2'b11;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("rotation", gnt_a, 32'(rot_seq[i]));
      chk("rot_model", exp_gnt(ma), 32'(rot_seq[i]));
    end

    // Owner 0 releases with requester 1 pending: immediate handoff.
    req_a = 2'b10;
    cyc();
    chk("handoff", gnt_a, 32'd2);

    // Lone requester 1 keeps the grant well past the hold limit.
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("lone_hold", gnt_a, 32'd2);
    end
    req_a = 2'b00;
    cyc();
    chk("idle_grant", gnt_a, 32'd0);
    chk("idle_valid", vld_a, 32'd0);
    chk("unlimited", gnt_c, 32'd1);

    // Reset while requester 1 owns: outputs clear without a clock edge.
    req_c = 2'b00;
    req_a = 2'b10;
    cyc();
    chk("pre_mid_reset", gnt_a, 32'd2);
    #1 rst = 1'b0;
    #1;
    chk("async_grant", gnt_a, 32'd0);
    chk("async_valid", vld_a, 32'd0);
    #1 rst = 1'b1;
    req_a = 2'b11;
    cyc();
    chk("post_reset_winner", gnt_a, 32'd1);

    // Wrap-around on the 4-requester instance (last = 3 out of reset).
    req_d = 4'b1001;
    cyc();
    chk("wrap_first", gnt_d, 32'h1);
    req_d = 4'b1000;
    cyc();
    chk("wrap_handoff", gnt_d, 32'h8);

    // Randomized phase: sticky requests with occasional mid-cycle resets.
    for (int t = 0; t < 3000; t++) begin
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(3) == 0) req_a[b] = ~req_a[b];
        if ($urandom_range(3) == 0) req_c[b] = ~req_c[b];
      end
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(4) == 0) req_d[b] = ~req_d[b];
      end
      if ($urandom_range(499) == 0) begin
        #1 rst = 1'b0;
        #2 rst = 1'b1;
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Parameterised round-robin arbiter that shares one resource among `N` requesters. Each requester holds its `request` line for as long as it needs the resource. The grant is registered, one-hot, and held while the owner keeps requesting, up to a programmable hold limit. Once that limit is reached, ownership rotates to the next pending requester. The block is the DUT for the team's arbiter testbench (2-bit `request`/`grant` in the default configuration) and drops in wherever a shared bus or memory port needs fair sharing.

## Interface
- `N`, default 2: number of requesters; minimum 2.
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while others are waiting; 0 means unlimited.
- `clk`  input  1  sole clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `request`  input  N  per-requester request level; bit i high means requester i wants or keeps the resource.
- `grant`  output  N  registered one-hot grant; all-zero when idle.
- `grant_valid`  output  1  registered; equals `|grant`.
- `grant_id`  output  $clog2(N)  registered index of the current owner; 0 when idle.

## Operation
- State machine `ARB_IDLE` / `ARB_BUSY`, plus the following registers:
  - `last`: index of the most recent owner; reset value N-1, so requester 0 has first priority.
  - `cnt`: grant cycles used by the current owner; width $clog2(MAX_HOLD+1), minimum 1.
- Pick function: take the first set bit of a candidate vector, searching from `(last+1) mod N` upward with wrap-around.
- `ARB_IDLE`:
  - If `request != 0`: winner = pick(`request`); grant winner; `last <= winner`; `cnt <= 1`; go to `ARB_BUSY`.
  - Otherwise stay in `ARB_IDLE`.
- `ARB_BUSY`, with owner `o = last`, evaluated in this priority order:
  1. If `request[o] == 0` and other requests are pending: hand off to pick(`request`) in the same edge, with no idle bubble; `cnt <= 1`.
  2. If `request[o] == 0` and no other requests are pending: `grant <= 0`; go to `ARB_IDLE`.
  3. If `MAX_HOLD != 0`, `cnt == MAX_HOLD`, and `request & ~(1<<o)` is non-zero: rotate to pick(`request & ~(1<<o)`); `cnt <= 1`.
  4. Otherwise: keep the grant; `cnt` increments and saturates at `MAX_HOLD`. With no competitors the owner keeps the grant indefinitely.
- At most one `grant` bit is ever high. `grant_id` and `grant_valid` always agree with `grant`.

## Timing
- Reset (async assert, sync-safe release): `grant = 0`, `grant_valid = 0`, `grant_id = 0`, state `ARB_IDLE`, `last = N-1`, `cnt = 0`.
- Reset asserted mid-grant clears all outputs immediately, without waiting for a clock edge.
- Latency: a request sampled at edge k produces `grant` at edge k (visible after the edge); first grant is 1 cycle from request.
- Handoff on release or rotation takes effect at the same edge; the new owner's grant appears with zero gap.
- Release to idle: `grant` drops at the first edge where the owner's request is sampled low.
- Hold window: with `MAX_HOLD = M` and a competitor waiting, the owner holds exactly M consecutive cycles.
- Simultaneous requests out of reset: the lowest index wins. After that, requesters are served in rotating order.
- A request that drops before it is sampled is never granted; there is no latching of requests.

## Structure
- Package `arb_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e`.
  - Shared helper function `onehot_to_idx`.
- Sub-module `rr_pick`: purely combinational rotating-priority picker.
  - Inputs: `req[N]`, `start` index.
  - Outputs: `found`, `idx`, one-hot `sel`.
  - Instantiated once in the top level; the candidate vector is muxed in front of it.
- All registered state lives in `rr_hold_arbiter`; outputs are driven directly from flops.

## Test plan
- Reset: rst low at t=0 to 12, request=01 at t=14 → grant=01 after the next posedge and still 01 two edges later; before that grant=00.
- Simultaneous: request=11 from reset with MAX_HOLD=4 → grant 01 for 4 cycles, then 10 for 4, then 01, repeating; never 11.
- Release handoff: owner 0 holding, requester 1 pending, request[0] dropped → grant=10 at the next edge, no 00 cycle between.
- Idle return: only requester 1 requests for 10 cycles then drops → grant=10 for 10 cycles despite MAX_HOLD=4, then 00 and grant_valid=0.
- Wrap-around: N=4, last=3, request=1001 → grant=0001; then request=1000 → grant=1000 at the next edge.
- Reset mid-grant and MAX_HOLD=0:
  - rst pulsed low while grant=10 → outputs 0 immediately; the next grant goes to requester 0 when request=11.
  - MAX_HOLD=0 with request=11 → grant stays 01 indefinitely.
